// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit to each frame).
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

`ifdef PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Bits on the wire per word: the data bits plus the optional parity bit.
    function automatic int frameLen(input int width, input bit parityEn);
        return parityEn ? width + 1 : width;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, shift-enable stall,
// back-to-back reload on the last bit and first/last frame markers.
// Optional feature macro: PISO_PARITY_EN (even-parity bit appended after the data).
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_first,
    output logic             frame_last,
    output logic             busy
);

    localparam int FRAME_LEN = frameLen(WIDTH, PARITY_EN);
    localparam int CW        = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             inShift;
    logic             isLast;
    logic             dataBit;
    logic             accept;

`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Decode frame position and select the bit currently presented on the line.
    always_comb begin
        inShift     = (state_q == SHIFT);
        isLast      = inShift && (cnt_q == LAST_CNT);
        dataBit     = MSB_FIRST ? shiftReg_q[WIDTH-1] : shiftReg_q[0];
`ifdef PISO_PARITY_EN
        if (isLast) begin
            dataBit = parity_q;
        end
`endif
        load_ready  = (state_q == IDLE) || (isLast && shift_en);
        accept      = load_valid && load_ready;
        ser_out     = inShift && dataBit;
        ser_valid   = inShift;
        busy        = inShift;
        frame_first = inShift && (cnt_q == '0);
        frame_last  = isLast;
    end

    // Next-state logic: load on a handshake, shift when enabled, hold on a stall.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        cnt_d      = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SHIFT;
                    shiftReg_d = load_data;
                    cnt_d      = '0;
`ifdef PISO_PARITY_EN
                    parity_d   = ^load_data;
`endif
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (isLast) begin
                        if (accept) begin
                            shiftReg_d = load_data;
                            cnt_d      = '0;
`ifdef PISO_PARITY_EN
                            parity_d   = ^load_data;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shiftReg_d = MSB_FIRST ? {shiftReg_q[WIDTH-2:0], 1'b0}
                                               : {1'b0, shiftReg_q[WIDTH-1:1]};
                        cnt_d      = cnt_q + CW'(1);
                    end
                end
            end
        endcase
    end

    // State register; a synchronous reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            cnt_q      <= '0;
`ifdef PISO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            cnt_q      <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance
// share the same stimulus; expected bit sequences are written out by hand.
module tb_piso_serializer;
    import piso_pkg::*;

    localparam int FL = frameLen(8, PARITY_EN);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       loadValid = 1'b0;
    logic [7:0] loadData = 8'h00;
    logic       shiftEn = 1'b0;

    logic msbReady, msbOut, msbValid, msbFirst, msbLast, msbBusy;
    logic lsbReady, lsbOut, lsbValid, lsbFirst, lsbLast, lsbBusy;

    int checks = 0;
    int errors = 0;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(msbReady),
        .load_data(loadData), .shift_en(shiftEn), .ser_out(msbOut),
        .ser_valid(msbValid), .frame_first(msbFirst), .frame_last(msbLast),
        .busy(msbBusy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(lsbReady),
        .load_data(loadData), .shift_en(shiftEn), .ser_out(lsbOut),
        .ser_valid(lsbValid), .frame_first(lsbFirst), .frame_last(lsbLast),
        .busy(lsbBusy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Inputs change on the falling edge so they are settled before the rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d, input logic s);
        @(negedge clk);
        rst       = r;
        loadValid = v;
        loadData  = d;
        shiftEn   = s;
    endtask

    task automatic checkOne(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Compare every output of both instances against the expected frame position.
    task automatic checkOutput(input string tag, input logic expM, input logic expL,
                               input logic expValid, input logic expFirst,
                               input logic expLast, input logic expReady);
        checkOne({tag, ".msb_out"},   msbOut,   expM);
        checkOne({tag, ".lsb_out"},   lsbOut,   expL);
        checkOne({tag, ".valid"},     msbValid, expValid);
        checkOne({tag, ".busy"},      msbBusy,  expValid);
        checkOne({tag, ".first"},     msbFirst, expFirst);
        checkOne({tag, ".last"},      msbLast,  expLast);
        checkOne({tag, ".ready"},     msbReady, expReady);
        checkOne({tag, ".lsb_valid"}, lsbValid, expValid);
        checkOne({tag, ".lsb_busy"},  lsbBusy,  expValid);
        checkOne({tag, ".lsb_first"}, lsbFirst, expFirst);
        checkOne({tag, ".lsb_last"},  lsbLast,  expLast);
        checkOne({tag, ".lsb_ready"}, lsbReady, expReady);
    endtask

    // Offer a word while idle; it is accepted on the following rising edge.
    task automatic sendWord(input string tag, input logic [7:0] word);
        applyStimulus(1'b0, 1'b1, word, 1'b1);
        #1;
        checkOutput({tag, ".load"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Walk one frame bit by bit. seqM/seqL list the expected data bits, first bit
    // in position 7; par is the expected parity bit when the frame carries one.
    task automatic runFrame(input string tag, input logic [7:0] seqM, input logic [7:0] seqL,
                            input logic par, input int stallAt, input int stallLen,
                            input logic holdValid, input logic [7:0] nextWord, input int abortAt);
        for (int i = 0; i < FL; i++) begin
            logic expM;
            logic expL;
            logic first;
            logic last;
            expM  = (i < 8) ? seqM[7-i] : par;
            expL  = (i < 8) ? seqL[7-i] : par;
            first = (i == 0);
            last  = (i == FL - 1);
            if (i == stallAt) begin
                for (int s = 0; s < stallLen; s++) begin
                    applyStimulus(1'b0, holdValid, nextWord, 1'b0);
                    #1;
                    checkOutput($sformatf("%s.stall%0d_%0d", tag, i, s), expM, expL, 1'b1, first, last, 1'b0);
                end
            end
            if (i == abortAt) begin
                applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
                #1;
                checkOutput($sformatf("%s.rstbit%0d", tag, i), expM, expL, 1'b1, first, last, last);
                applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
                #1;
                checkOutput({tag, ".afterrst"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            applyStimulus(1'b0, holdValid, nextWord, 1'b1);
            #1;
            checkOutput($sformatf("%s.bit%0d", tag, i), expM, expL, 1'b1, first, last, last);
        end
    endtask

    // After a frame without reload the line must be idle and ready.
    task automatic expectIdle(input string tag);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        #1;
        checkOutput({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Directed sequence of tests.
    initial begin
        $display("[TB] piso_serializer bench, frame length %0d", FL);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Single word, both bit orders.
        sendWord("b4", 8'hB4);
        runFrame("b4", 8'b1011_0100, 8'b0010_1101, 1'b0, -1, 0, 1'b0, 8'h00, -1);
        expectIdle("b4");

        // Back-to-back words with load_valid held high.
        sendWord("ff", 8'hFF);
        runFrame("ff", 8'b1111_1111, 8'b1111_1111, 1'b0, -1, 0, 1'b1, 8'h00, -1);
        runFrame("00", 8'b0000_0000, 8'b0000_0000, 1'b0, -1, 0, 1'b0, 8'h00, -1);
        expectIdle("00");

        // Three-cycle stall on bit 3.
        sendWord("a5", 8'hA5);
        runFrame("a5", 8'b1010_0101, 8'b1010_0101, 1'b0, 3, 3, 1'b0, 8'h00, -1);
        expectIdle("a5");

        // Reset at bit 4 aborts the frame.
        sendWord("abort", 8'hB4);
        runFrame("abort", 8'b1011_0100, 8'b0010_1101, 1'b0, -1, 0, 1'b0, 8'h00, 4);

        // Reset wins over a simultaneous handshake while idle.
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
        #1;
        checkOutput("rstprio", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expectIdle("rstprio");

        // Clean frame after reset, stalled on its last bit with a reload pending.
        sendWord("81", 8'h81);
        runFrame("81", 8'b1000_0001, 8'b1000_0001, 1'b0, FL - 1, 2, 1'b1, 8'h3C, -1);
        runFrame("3c", 8'b0011_1100, 8'b0011_1100, 1'b0, -1, 0, 1'b0, 8'h00, -1);
        expectIdle("3c");

        // Words whose parity bit differs.
        sendWord("07", 8'h07);
        runFrame("07", 8'b0000_0111, 8'b1110_0000, 1'b1, -1, 0, 1'b0, 8'h00, -1);
        expectIdle("07");
        sendWord("03", 8'h03);
        runFrame("03", 8'b0000_0011, 8'b1100_0000, 1'b0, -1, 0, 1'b0, 8'h00, -1);
        expectIdle("03");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
